// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, rounding modes and
// special-value bit patterns for arbitrary exponent/mantissa widths.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Patterns are built in 64 bits with the sign bit clear; callers truncate.
  function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) - 64'd1;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits a packed float into sign, exponent and significand (hidden bit
// included) and classifies it; subnormals are reported as zero.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       sig,
  output fp_class_e            cls
);

  logic [MAN_W-1:0] frac;

  always_comb begin
    sign = op[EXP_W+MAN_W];
    expo = op[MAN_W +: EXP_W];
    frac = op[MAN_W-1:0];
    sig  = {1'b1, frac};
    cls  = NORM;
    if (&expo) begin
      cls = (frac == '0) ? INF : NAN;
    end else if (expo == '0) begin
      cls = ZERO;
      sig = '0;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (multiply, normalise,
// round/pack) with per-operation rounding mode and tag passthrough.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       in_a,
  input  logic [EXP_W+MAN_W:0]       in_b,
  input  logic                       in_rnd,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_exception,
  output logic                       out_overflow,
  output logic                       out_underflow
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam int MW = MAN_W + 2;

  localparam logic [W-1:0]          QNAN    = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-2:0]          INF_MAG = (W-1)'(fp_inf(EXP_W, MAN_W));
  localparam logic [W-2:0]          MAX_MAG = (W-1)'(fp_max_finite(EXP_W, MAN_W));
  localparam logic [XW-1:0]         BIAS_X  = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0]  EXP_MAX = XW'((1 << EXP_W) - 1);

  // Handshake: a pair transfers on in_valid && in_ready, a result on
  // out_valid && out_ready. The whole pipe advances in lockstep whenever the
  // output register is empty or being drained; otherwise every stage holds.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: classify, sign, exponent sum and significand product
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   sig_a, sig_b;
  fp_class_e        cls_a, cls_b;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op(in_a), .sign(sign_a), .expo(exp_a), .sig(sig_a), .cls(cls_a)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op(in_b), .sign(sign_b), .expo(exp_b), .sig(sig_b), .cls(cls_b)
  );

  logic                 nan_d, inf_d, zero_d;
  logic signed [XW-1:0] exp_sum_d;
  logic [PW-1:0]        prod_d;

  always_comb begin
    nan_d  = (cls_a == NAN) || (cls_b == NAN) ||
             (cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO);
    inf_d  = !nan_d && (cls_a == INF || cls_b == INF);
    zero_d = !nan_d && !inf_d && (cls_a == ZERO || cls_b == ZERO);
    exp_sum_d = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_X;
    prod_d    = PW'(sig_a) * PW'(sig_b);
  end

  logic                 s1_valid, s1_rnd, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [TAG_W-1:0]     s1_tag;
  logic signed [XW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  // Stage 2: normalise so the hidden bit sits at the top of the product
  logic [PW-1:0]        norm;
  logic signed [XW-1:0] exp_n_d;

  always_comb begin
    norm    = s1_prod[PW-1] ? s1_prod : (s1_prod << 1);
    exp_n_d = s1_exp + XW'(s1_prod[PW-1]);
  end

  logic                 s2_valid, s2_rnd, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [TAG_W-1:0]     s2_tag;
  logic signed [XW-1:0] s2_exp;
  logic [MAN_W:0]       s2_mant;
  logic                 s2_guard, s2_round, s2_sticky;

  // Stage 3: round, renormalise on carry-out, resolve special cases, pack
  logic                 inc, carry;
  logic [MW-1:0]        mant_r;
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         res_d;
  logic                 exc_d, ovf_d, unf_d;

  always_comb begin
    inc    = (s2_rnd == RND_RNE) && s2_guard && (s2_round || s2_sticky || s2_mant[0]);
    mant_r = {1'b0, s2_mant} + MW'(inc);
    carry  = mant_r[MW-1];
    frac_r = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    exp_r  = s2_exp + XW'(carry);
    res_d  = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    exc_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (s2_nan) begin
      res_d = QNAN;
      exc_d = 1'b1;
    end else if (s2_inf) begin
      res_d = {s2_sign, INF_MAG};
    end else if (s2_zero) begin
      res_d = {s2_sign, {(W-1){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      res_d = (s2_rnd == RND_RTZ) ? {s2_sign, MAX_MAG} : {s2_sign, INF_MAG};
      ovf_d = 1'b1;
    end else if (exp_r[XW-1] || exp_r == '0) begin
      res_d = {s2_sign, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_rnd <= 1'b0; s1_sign <= 1'b0; s1_tag <= '0;
      s1_nan <= 1'b0; s1_inf <= 1'b0; s1_zero <= 1'b0;
      s1_exp <= '0; s1_prod <= '0;
      s2_valid <= 1'b0; s2_rnd <= 1'b0; s2_sign <= 1'b0; s2_tag <= '0;
      s2_nan <= 1'b0; s2_inf <= 1'b0; s2_zero <= 1'b0;
      s2_exp <= '0; s2_mant <= '0;
      s2_guard <= 1'b0; s2_round <= 1'b0; s2_sticky <= 1'b0;
      out_valid <= 1'b0; out_result <= '0; out_tag <= '0;
      out_exception <= 1'b0; out_overflow <= 1'b0; out_underflow <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_rnd   <= in_rnd;
      s1_sign  <= sign_a ^ sign_b;
      s1_tag   <= in_tag;
      s1_nan   <= nan_d;
      s1_inf   <= inf_d;
      s1_zero  <= zero_d;
      s1_exp   <= exp_sum_d;
      s1_prod  <= prod_d;

      s2_valid  <= s1_valid;
      s2_rnd    <= s1_rnd;
      s2_sign   <= s1_sign;
      s2_tag    <= s1_tag;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_exp    <= exp_n_d;
      s2_mant   <= norm[PW-1 -: MAN_W+1];
      s2_guard  <= norm[MAN_W];
      s2_round  <= norm[MAN_W-1];
      s2_sticky <= |norm[MAN_W-2:0];

      out_valid     <= s2_valid;
      out_result    <= res_d;
      out_tag       <= s2_tag;
      out_exception <= exc_d;
      out_overflow  <= ovf_d;
      out_underflow <= unf_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (FP32 configuration): directed vectors
// through a scoreboard queue, backpressure streaming and mid-flight reset.
module tb_fp_mul_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int TAG_W = 4;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EW    = TAG_W + 3 + W;

  // Expected flags packed as {exception, overflow, underflow}
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_EXC  = 3'b100;
  localparam logic [2:0] F_OVF  = 3'b010;
  localparam logic [2:0] F_UNF  = 3'b001;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rnd;
    logic [W+2:0] expv;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             in_rnd = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_exception, out_overflow, out_underflow;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  vec_t arith_v [7] = '{
    '{32'h41200000, 32'h40A00000, 1'b0, {F_NONE, 32'h42480000}},
    '{32'h7F7FFFFF, 32'h00800000, 1'b0, {F_NONE, 32'h407FFFFF}},
    '{32'h3F800001, 32'h3FC00000, 1'b0, {F_NONE, 32'h3FC00002}},
    '{32'h3F800001, 32'h3FC00000, 1'b1, {F_NONE, 32'h3FC00001}},
    '{32'h40000000, 32'h40400000, 1'b0, {F_NONE, 32'h40C00000}},
    '{32'hC0000000, 32'h3F000000, 1'b0, {F_NONE, 32'hBF800000}},
    '{32'h3F800001, 32'h3FFFFFFF, 1'b0, {F_NONE, 32'h40000000}}
  };

  vec_t special_v [10] = '{
    '{32'h7E967699, 32'h49F423FA, 1'b0, {F_OVF,  32'h7F800000}},
    '{32'h7E967699, 32'h49F423FA, 1'b1, {F_OVF,  32'h7F7FFFFF}},
    '{32'h00800001, 32'h00800001, 1'b0, {F_UNF,  32'h00000000}},
    '{32'h80800001, 32'h00800001, 1'b0, {F_UNF,  32'h80000000}},
    '{32'h00000000, 32'h7F800000, 1'b0, {F_EXC,  32'h7FC00000}},
    '{32'h80000000, 32'h40000000, 1'b0, {F_NONE, 32'h80000000}},
    '{32'h7FC00001, 32'h3F800000, 1'b0, {F_EXC,  32'h7FC00000}},
    '{32'h7F800000, 32'hC0000000, 1'b0, {F_NONE, 32'hFF800000}},
    '{32'h00000001, 32'h40000000, 1'b0, {F_NONE, 32'h00000000}},
    '{32'hFF800000, 32'h80000000, 1'b0, {F_EXC,  32'h7FC00000}}
  };

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_exception(out_exception), .out_overflow(out_overflow),
    .out_underflow(out_underflow)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Driver: called at a falling edge; holds the pair until accepted, pushes
  // the expected response, returns on the falling edge after the transfer.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rnd, input logic [TAG_W-1:0] tag,
                          input logic [W+2:0] expv);
    int waited;
    waited = 0;
    in_a = a; in_b = b; in_rnd = rnd; in_tag = tag; in_valid = 1'b1;
    #2;
    while (!in_ready && waited < 100) begin
      @(negedge clk); #2;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: tag %0d in_ready=%b required 1", tag, in_ready);
    end else begin
      exp_q.push_back({tag, expv});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [EW-1:0] observed();
    return {out_tag, out_exception, out_overflow, out_underflow, out_result};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (observed() !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: out_valid=%b outputs=%h required 0/0", out_valid, observed());
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (observed() !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b outputs=%h required 0/0", out_valid, observed());
    end
    @(negedge clk);
  endtask

  task automatic test_arith();
    foreach (arith_v[i]) begin
      logic [EW-1:0] exp_e;
      int cyc;
      drive_op(arith_v[i].a, arith_v[i].b, arith_v[i].rnd, TAG_W'(i), arith_v[i].expv);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (!out_valid || exp_q.size() == 0) begin
        errors++;
        $display("FAIL arith_timeout[%0d]: out_valid=%b required 1", i, out_valid);
      end else begin
        exp_e = exp_q.pop_front();
        // Rising edges from and including the accept edge up to out_valid
        if (i == 0) begin
          checks++;
          if (cyc + 1 != 3) begin
            errors++;
            $display("FAIL arith_latency: got %0d edges required 3", cyc + 1);
          end
        end
        if (observed() !== exp_e) begin
          errors++;
          $display("FAIL arith[%0d]: got tag/exc/ovf/unf/result=%h required %h", i, observed(), exp_e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_special();
    foreach (special_v[i]) begin
      logic [EW-1:0] exp_e;
      int cyc;
      drive_op(special_v[i].a, special_v[i].b, special_v[i].rnd, TAG_W'(i), special_v[i].expv);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (!out_valid || exp_q.size() == 0) begin
        errors++;
        $display("FAIL special_timeout[%0d]: out_valid=%b required 1", i, out_valid);
      end else begin
        exp_e = exp_q.pop_front();
        if (observed() !== exp_e) begin
          errors++;
          $display("FAIL special[%0d]: got tag/exc/ovf/unf/result=%h required %h", i, observed(), exp_e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    logic saw_block;
    got = 0;
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive_op(arith_v[i].a, arith_v[i].b, arith_v[i].rnd, TAG_W'(i), arith_v[i].expv);
      end
      begin
        int cyc;
        logic [EW-1:0] exp_e;
        cyc = 0;
        while (got < 6 && cyc < 80) begin
          #1;
          out_ready = !(cyc >= 2 && cyc < 12);
          if (!in_ready) saw_block = 1'b1;
          if (out_valid && !out_ready) begin
            checks++;
            if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
              errors++;
              $display("FAIL stall_stable: cycle %0d got %h required %h", cyc, observed(),
                       (exp_q.size() == 0) ? '0 : exp_q[0]);
            end
          end
          if (out_valid && out_ready) begin
            checks++;
            exp_e = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
            if (observed() !== exp_e) begin
              errors++;
              $display("FAIL b2b_order[%0d]: got %h required %h", got, observed(), exp_e);
            end
            got++;
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d results required 6", got);
    end
    checks++;
    if (!saw_block) begin
      errors++;
      $display("FAIL b2b_in_ready: in_ready low seen=%b required 1", saw_block);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_leftover: %0d expected results unclaimed required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      drive_op(arith_v[i].a, arith_v[i].b, arith_v[i].rnd, TAG_W'(i + 8), arith_v[i].expv);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || observed() !== '0) begin
      errors++;
      $display("FAIL inflight_reset: out_valid=%b outputs=%h required 0/0", out_valid, observed());
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL inflight_stale: out_valid seen=%b after release required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, pipelined IEEE-754 binary floating-point multiplier. It generalises the team's combinational FP32Multiplier to configurable exponent/mantissa widths, a fixed 3-stage pipeline, and a valid/ready handshake with backpressure. It adds a per-operation rounding mode and a tag passthrough. It is the multiply lane feeding the matrix-multiplier accumulate path.

Parameters:
EXP_W, 8, exponent field width.
MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  block accepts an operand pair this cycle.
in_a  in  W  operand A.
in_b  in  W  operand B.
in_rnd  in  1  rounding mode: 0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ).
in_tag  in  TAG_W  tag, returned unchanged with the result.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_result  out  W  packed product.
out_tag  out  TAG_W  tag of this result.
out_exception  out  1  invalid operation (NaN result).
out_overflow  out  1  result overflowed.
out_underflow  out  1  result underflowed.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, out_valid = 0, out_result = 0, out_tag = 0, all flags = 0. in_ready = 1 once reset is released.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. Transfer occurs on in_valid && in_ready.
- When en = 1, all stages advance together and bubbles propagate; empty stages are not collapsed. When en = 0, every stage register holds and outputs stay stable.
- Latency is exactly 3 cycles from accept to out_valid when unstalled. Throughput is 1 operation per cycle. Ordering is strictly FIFO.
- Stage 1: unpack and classify each operand as zero, subnormal, normal, Inf or NaN. Subnormal inputs flush to zero. Sign = a.sign XOR b.sign. Exponent sum = ea + eb − bias, signed, EXP_W+2 bits. Significand product is (MAN_W+1)×(MAN_W+1) → 2·MAN_W+2 bits.
- Stage 2: normalise. If the product MSB is set, shift right by 1 and increment the exponent. Form guard bit, round bit and sticky bit (OR of all lower bits).
- Stage 3: round, post-round renormalise (a mantissa carry-out increments the exponent), special-case override, pack.
- RNE: increment when guard && (round || sticky || lsb). RTZ: truncate.
- Special cases, in priority order:
  - Either operand NaN, or zero×Inf → canonical quiet NaN (exp all ones, fraction MSB = 1, sign 0), exception = 1.
  - Inf×nonzero → signed Inf, no flags.
  - Zero (including flushed subnormal) × finite → signed zero, no flags.
  - Rounded biased exponent ≥ 2^EXP_W − 1 → overflow = 1. RNE gives signed Inf; RTZ gives signed max finite.
  - Rounded biased exponent ≤ 0 → signed zero, underflow = 1. Subnormal outputs are flushed.
- At most one flag is set per result.
- out_tag and in_rnd travel with their data through every stage.
- Reset mid-operation: all in-flight operations are discarded and no out_valid is produced for them.

Decomposition:
- Shared package fp_pkg holds: the float-class enum (ZERO, NORM, INF, NAN), the rounding-mode constants, and functions for bias, quiet-NaN, Inf and max-finite patterns parametrised on EXP_W/MAN_W.
- One sub-module, fp_unpack, does field extraction and classification. It is instantiated twice in stage 1.

Test Plan:
- 0x41200000 × 0x40A00000, RNE → 0x42480000 exactly 3 cycles after accept, no flags; 0x7F7FFFFF × 0x00800000 → 0x407FFFFF.
- RNE tie: 0x3F800001 × 0x3FC00000 → RNE gives 0x3FC00002; RTZ gives 0x3FC00001.
- 0x7E967699 × 0x49F423FA → RNE gives 0x7F800000 with overflow = 1; RTZ gives 0x7F7FFFFF with overflow = 1.
- 0x00800001 × 0x00800001 → 0x00000000, underflow = 1. 0x00000000 × 0x7F800000 → 0x7FC00000, exception = 1. 0x80000000 × 0x40000000 → 0x80000000, no flags.
- Backpressure: stream 6 back-to-back operations with tags 0..5 and hold out_ready = 0 from cycle 2.
  - in_ready must drop once the pipe is full.
  - out_result and out_tag must stay stable while stalled.
  - After out_ready is released, all 6 results must appear in tag order with none lost or duplicated.
- Assert rst_n low with 3 operations in flight → outputs go to reset values immediately and no stale out_valid appears after release.
